cpu_boot_ctrl: RTL and testbench
================================

# cpu_boot_ctrl

Boot and run sequencer for the single-cycle RISC-V `cpu`. It accepts a program word stream over a valid/ready port, writes it into instruction memory, and keeps the CPU in reset until loading completes. It then releases the CPU, counts executed cycles, and re-asserts CPU reset on a halt request or, optionally, a watchdog expiry. It sits between the bench/loader and the `cpu`, driving the CPU reset and the instruction-memory write port.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width (depth 2^ADDR_W words).
- `HOLD_CYCLES`, 2: cycles CPU reset stays high after the last write (1..15).
- `MAX_CYCLES`, 1024: watchdog limit in RUN (used only with `BOOT_WATCHDOG_EN`).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ld_valid` in 1: loader word valid.
- `ld_ready` out 1: controller accepts a word.
- `ld_data` in 32: program word.
- `ld_last` in 1: marks the final word; qualified by `ld_valid`.
- `imem_we` out 1: instruction-memory write enable.
- `imem_addr` out ADDR_W: write word address.
- `imem_wdata` out 32: write data.
- `cpu_rst` out 1: reset to `cpu`.
- `cpu_halt` in 1: halt request from the CPU, sampled in RUN.
- `restart` in 1: in DONE, returns to IDLE.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `timeout` out 1: DONE was entered by the watchdog.
- `cycle_count` out 32: RUN cycles elapsed.

## Operation
- FSM states: IDLE, LOAD, HOLD, RUN, DONE.
- Reset values: state=IDLE, `cpu_rst`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `running`=0, `done`=0, `timeout`=0, `cycle_count`=0, internal write pointer=0.
- `ld_ready`=1 in IDLE and LOAD, 0 elsewhere.
- A handshake occurs when `ld_valid` and `ld_ready` are both high.
- IDLE: on the first handshake, write the word at address 0 and go to LOAD. If `ld_last` is set, go directly to HOLD.
- LOAD: each handshake writes at the pointer, then increments it. Go to HOLD on `ld_last`, or when the word is written at address 2^ADDR_W-1 (memory full). The pointer never wraps.
- HOLD: `cpu_rst`=1 for exactly HOLD_CYCLES cycles, then go to RUN.
- RUN:
  - `cpu_rst`=0, `running`=1.
  - `cycle_count` increments every cycle and saturates at 0xFFFF_FFFF.
  - `cpu_halt`=1 → DONE.
- DONE:
  - `cpu_rst`=1, `done`=1.
  - `cycle_count` and `timeout` hold their values.
  - `restart` → IDLE: pointer, `cycle_count` and `timeout` clear.
- `cpu_halt` is ignored outside RUN. `restart` is ignored outside DONE.
- Async `rst` at any point, including mid-load and mid-run, forces reset values immediately. The CPU is held in reset throughout.

## Timing
- All outputs are registered except `ld_ready`, which is decoded from state.
- Memory write latency: `imem_we`, `imem_addr` and `imem_wdata` are valid the cycle after the handshake, for one cycle per word.
- Back-to-back handshakes produce one write per cycle.
- HOLD starts the cycle after the final handshake. `cpu_rst` falls exactly HOLD_CYCLES cycles later, together with `running` rising.
- `cycle_count` is 1 in the first RUN cycle.
- Halt: `cpu_halt` high in a RUN cycle → the next cycle is DONE, with `cpu_rst`=1 and `done`=1.
- If halt and watchdog expiry occur in the same cycle, halt wins and `timeout`=0.

## Configuration
- Macro `BOOT_WATCHDOG_EN`.
- Defined: in RUN, when `cycle_count` reaches MAX_CYCLES without a halt, go to DONE with `timeout`=1.
- Undefined: no watchdog logic; `timeout` is tied to 0; RUN exits only on `cpu_halt` or `rst`.

## Structure
- Shared package `boot_pkg`:
  - state enum `boot_state_t` (IDLE, LOAD, HOLD, RUN, DONE);
  - `WORD_W`=32;
  - `CNT_W`=32.
- One natural sub-module, `boot_cycle_cnt`: saturating counter with clear and enable, plus a limit compare. It serves as the RUN cycle counter and watchdog compare. The HOLD counter stays inline.

## Test plan
- Load 3 words 0x00500093, 0x00100113, 0x002081B3, `ld_last` on the third, back-to-back → writes at addresses 0,1,2 on consecutive cycles; `cpu_rst` falls 2 cycles after the last write cycle.
- Loader stalls: `ld_valid` low for 3 cycles between words → no `imem_we` during the gap; addresses stay contiguous.
- Run, then `cpu_halt` pulsed in the 10th RUN cycle → `done`=1 and `cpu_rst`=1 next cycle; `cycle_count`=10; `timeout`=0.
- With `BOOT_WATCHDOG_EN` and MAX_CYCLES=16, no halt → DONE with `timeout`=1 and `cycle_count`=16. Without the macro, still RUN at cycle 100.
- Assert `rst` mid-LOAD after 5 words, then reload 2 words → the first new write is at address 0; `cycle_count`=0.
- ADDR_W=2, stream 6 words without `ld_last` → 4 writes (addresses 0..3), `ld_ready` low from HOLD onward, RUN entered; the `restart` from DONE returns to IDLE with `ld_ready`=1.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and widths for the cpu_boot_ctrl boot/run sequencer.
package boot_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } boot_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/boot_cycle_cnt.sv
// Saturating RUN cycle counter with synchronous clear/enable and a limit compare
// that feeds the optional watchdog.
module boot_cycle_cnt
    import boot_pkg::*;
#(
    parameter int LIMIT    = 1024,
    parameter bit LIMIT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(LIMIT);

    // Count register; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (clr) begin
            count <= {CNT_W{1'b0}};
        end else if (en) begin
            count <= sat_inc(count);
        end else begin
            count <= count;
        end
    end

    assign at_limit = LIMIT_EN && (count == LIMIT_VAL);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: streams program words into instruction memory, holds the CPU in
// reset, releases it and times the run. Define BOOT_WATCHDOG_EN to add the RUN watchdog.
module cpu_boot_ctrl
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int MAX_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    input  logic              restart,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

`ifdef BOOT_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
    localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);

    boot_state_t       state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [3:0]        hold_cnt_r;

    logic handshake_s;
    logic hold_done_s;
    logic wd_hit_s;
    logic cnt_en_s;
    logic cnt_clr_s;

    assign ld_ready    = (state_r == IDLE) || (state_r == LOAD);
    assign handshake_s = ld_valid && ld_ready;
    assign hold_done_s = (state_r == HOLD) && (hold_cnt_r == HOLD_LAST);

    // Ticking on the HOLD->RUN edge makes the first RUN cycle read 1; the count freezes on exit.
    assign cnt_en_s  = hold_done_s || ((state_r == RUN) && !cpu_halt && !wd_hit_s);
    assign cnt_clr_s = (state_r == DONE) && restart;

    boot_cycle_cnt #(
        .LIMIT    (MAX_CYCLES),
        .LIMIT_EN (WD_EN)
    ) u_cycle_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .en       (cnt_en_s),
        .count    (cycle_count),
        .at_limit (wd_hit_s)
    );

    // Sequencer state, load pointer, memory write port and CPU control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= {ADDR_W{1'b0}};
            hold_cnt_r <= 4'd0;
            cpu_rst    <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= {WORD_W{1'b0}};
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            imem_we <= handshake_s;
            if (handshake_s) begin
                imem_addr  <= ptr_r;
                imem_wdata <= ld_data;
            end

            case (state_r)
                IDLE, LOAD: begin
                    if (handshake_s) begin
                        // The pointer parks on the last word rather than wrapping.
                        if (ptr_r != PTR_LAST) begin
                            ptr_r <= ptr_r + ADDR_W'(1'b1);
                        end
                        if (ld_last || (ptr_r == PTR_LAST)) begin
                            state_r    <= HOLD;
                            hold_cnt_r <= 4'd0;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_done_s) begin
                        state_r <= RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 4'd1;
                    end
                end
                RUN: begin
                    if (cpu_halt || wd_hit_s) begin
                        state_r <= DONE;
                        cpu_rst <= 1'b1;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    if (restart) begin
                        state_r <= IDLE;
                        ptr_r   <= {ADDR_W{1'b0}};
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ptr_r   <= {ADDR_W{1'b0}};
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BOOT_WATCHDOG_EN
    // Timeout flag: only a watchdog exit sets it; a simultaneous halt takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if ((state_r == RUN) && wd_hit_s && !cpu_halt) begin
            timeout <= 1'b1;
        end else if (cnt_clr_s) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Scoreboard bench for cpu_boot_ctrl: random load/run sessions; expected writes and
// run results are queued at issue time and checked by an independent monitor.
module tb_cpu_boot_ctrl;

    localparam int AW    = 3;
    localparam int HOLD  = 2;
    localparam int MAXC  = 16;
    localparam int DEPTH = 1 << AW;
`ifdef BOOT_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          cpu_halt;
    logic          restart;
    logic          running;
    logic          done;
    logic          timeout;
    logic [31:0]   cycle_count;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { int count; bit to; } res_t;

    wr_t wq[$];
    res_t rq[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_boot_ctrl #(
        .ADDR_W      (AW),
        .HOLD_CYCLES (HOLD),
        .MAX_CYCLES  (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_rst     (cpu_rst),
        .cpu_halt    (cpu_halt),
        .restart     (restart),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every memory write, release timing and run result against the queues.
    int   cyc = 0;
    int   last_we_cyc = 0;
    logic prev_cpu_rst = 1'b1;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        wr_t w;
        res_t r;
        cyc++;
        if (!rst) begin
            if (imem_we) begin
                if (wq.size() == 0) begin
                    check("spurious_write", imem_we, 1'b0);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(imem_addr), w.addr);
                    check("wr_data", imem_wdata, w.data);
                end
                last_we_cyc = cyc;
            end
            if (prev_cpu_rst && !cpu_rst) begin
                check("hold_len", 32'(cyc - last_we_cyc), HOLD);
                check("run_first_count", cycle_count, 1);
                check("running_rise", running, 1'b1);
            end
            if (done && !prev_done) begin
                if (rq.size() == 0) begin
                    check("spurious_done", done, 1'b0);
                end else begin
                    r = rq.pop_front();
                    check("done_count", cycle_count, r.count);
                    check("done_timeout", timeout, r.to);
                    check("done_cpu_rst", cpu_rst, 1'b1);
                    check("done_running", running, 1'b0);
                end
            end
        end
        prev_cpu_rst = cpu_rst;
        prev_done    = done;
    end

    task automatic check_reset_values();
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_ld_ready", ld_ready, 1'b1);
    endtask

    // Offers one word after a gap; halt/restart are jittered since both must be ignored here.
    task automatic drive_word(input logic [31:0] data, input bit last, input int gap);
        int b;
        ld_valid = 1'b0;
        repeat (gap) @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        cpu_halt = 1'($urandom_range(0, 1));
        restart  = 1'($urandom_range(0, 1));
        b = 0;
        while (!ld_ready && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (b == 20) check("ready_wait", ld_ready, 1'b1);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        cpu_halt = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic load_session(input logic [31:0] words[$], input int last_idx, input bit b2b);
        int  acc;
        wr_t w;
        // Accepted words: up to the ld_last word, capped by memory depth.
        acc = (last_idx != 0 && last_idx < DEPTH) ? last_idx : DEPTH;
        for (int i = 0; i < acc; i++) begin
            w.addr = i;
            w.data = words[i];
            wq.push_back(w);
        end
        for (int i = 0; i < acc; i++) begin
            drive_word(words[i], (i + 1) == last_idx, b2b ? 0 : $urandom_range(0, 3));
        end
        if (words.size() > acc) begin
            ld_valid = 1'b1;
            ld_data  = words[acc];
            check("ready_low_after_load", ld_ready, 1'b0);
            @(negedge clk);
            check("ready_low_hold", ld_ready, 1'b0);
            ld_valid = 1'b0;
        end
    endtask

    task automatic run_session(input int h);
        res_t r;
        int   b;
        if (WD && h >= MAXC) begin
            r.count = MAXC;
            r.to    = (h > MAXC);
        end else begin
            r.count = h;
            r.to    = 1'b0;
        end
        rq.push_back(r);
        b = 0;
        while (!running && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("enter_run", running, 1'b1);
        repeat (h - 1) @(negedge clk);
        if (!r.to) check("still_running", running, 1'b1);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        b = 0;
        while (!done && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("done_seen", done, 1'b1);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        check("count_hold", cycle_count, r.count);
        check("timeout_hold", timeout, r.to);
        check("cpu_rst_in_done", cpu_rst, 1'b1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("ready_after_restart", ld_ready, 1'b1);
        check("count_cleared", cycle_count, 0);
        check("done_cleared", done, 1'b0);
        check("timeout_cleared", timeout, 1'b0);
    endtask

    task automatic reset_mid_load();
        wr_t w;
        for (int i = 0; i < 5; i++) begin
            w.addr = i;
            w.data = $urandom;
            wq.push_back(w);
            drive_word(w.data, 1'b0, $urandom_range(0, 2));
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        check("wq_drained_before_reset", 32'(wq.size()), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] words[$];
        int n;
        int last_idx;
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_data  = 32'd0;
        ld_last  = 1'b0;
        cpu_halt = 1'b0;
        restart  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        words = '{32'h00500093, 32'h00100113, 32'h002081B3};
        load_session(words, 3, 1'b1);
        run_session(10);

        words.delete();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        load_session(words, 4, 1'b0);
        run_session($urandom_range(1, 30));

        words.delete();
        for (int i = 0; i < 10; i++) words.push_back($urandom);
        load_session(words, 0, 1'b0);
        run_session(100);

        reset_mid_load();
        words.delete();
        for (int i = 0; i < 2; i++) words.push_back($urandom);
        load_session(words, 2, 1'b0);
        run_session($urandom_range(1, 24));

        for (int s = 0; s < 8; s++) begin
            n = $urandom_range(1, 12);
            last_idx = (n < DEPTH) ? $urandom_range(1, n) : $urandom_range(0, n);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            load_session(words, last_idx, 1'($urandom_range(0, 1)));
            run_session($urandom_range(1, 24));
        end

        repeat (2) @(negedge clk);
        check("wq_empty", 32'(wq.size()), 0);
        check("rq_empty", 32'(rq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
